serial_bin_to_bcd: RTL and testbench

Serial binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. Sits directly downstream of the serial 6x6 shift-add multiplier: it takes the 12-bit product once the multiplier has finished and produces four packed BCD digits for the lab board's seven-segment display driver. It uses a load/busy/done handshake so the controller can chain multiply → convert → display.

---
 rtl/serial_bin_to_bcd_if.sv | 28 ++
 rtl/serial_bin_to_bcd.sv | 92 +++++++++
 tb/tb_serial_bin_to_bcd.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_bin_to_bcd_if.sv
// Handshake bundle between the conversion controller and the BCD converter.
// The controller drives load/bin; the converter returns bcd/busy/done.
interface serial_bin_to_bcd_if #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
);
    logic                  load;
    logic [WIDTH-1:0]      bin;
    logic [4*DIGITS-1:0]   bcd;
    logic                  busy;
    logic                  done;

    modport master (
        output load,
        output bin,
        input  bcd,
        input  busy,
        input  done
    );

    modport slave (
        input  load,
        input  bin,
        output bcd,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_bin_to_bcd.sv
// Serial double-dabble binary-to-BCD converter, one bit per clock.
// Accepts a load in IDLE or DONE; result is held in bcd until the next conversion.
module serial_bin_to_bcd #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_bin_to_bcd_if.slave  io
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [BW-1:0]     scr_q, scr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bcd_q, bcd_d;

    logic [BW-1:0]       adj;
    logic [BW+WIDTH-1:0] shifted;

    // Add-3 correction on every digit before it is doubled by the shift
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5)
                          ? scr_q[4*i +: 4] + 4'd3
                          : scr_q[4*i +: 4];
        end
    end

    assign shifted = {adj, sh_q} << 1;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (io.load) begin
                    sh_d    = io.bin;
                    scr_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CONV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CONV: begin
                sh_d  = shifted[WIDTH-1:0];
                scr_d = shifted[WIDTH +: BW];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    bcd_d   = shifted[WIDTH +: BW];
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    assign io.bcd  = bcd_q;
    assign io.busy = (state_q == S_CONV);
    assign io.done = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_bin_to_bcd.sv
// Randomised bench for serial_bin_to_bcd against a decimal-digit reference.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_serial_bin_to_bcd;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    serial_bin_to_bcd_if #(.WIDTH(12), .DIGITS(4)) io ();

    serial_bin_to_bcd #(.WIDTH(12), .DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    // Reference: repeated division by ten, one decimal digit per nibble
    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load v, then clock until done (bounded). lat counts edges from the load edge.
    task automatic convert(input int v, output int lat, output int bc,
                           output logic [15:0] res, output bit ok);
        io.bin  = 12'(v);
        io.load = 1'b1;
        tick();
        io.load = 1'b0;
        lat = 1;
        bc  = io.busy ? 1 : 0;
        while (!io.done && lat < 40) begin
            io.bin = 12'($urandom);
            tick();
            lat++;
            if (io.busy) bc++;
        end
        ok  = io.done;
        res = io.bcd;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        io.load = 1'b1;
        io.bin  = 12'd4095;
        tick();
        tick();
        rst     = 1'b0;
        io.load = 1'b0;
        tick();
        total++;
        if (io.bcd !== 16'h0) begin
            bad++; $display("FAIL reset_bcd got=%h want=0000", io.bcd);
        end
        total++;
        if (io.busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%b want=0", io.busy);
        end
        total++;
        if (io.done !== 1'b0) begin
            bad++; $display("FAIL reset_done got=%b want=0", io.done);
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        logic [15:0] res;
        bit ok;
        convert(3969, lat, bc, res, ok);
        total++;
        if (!ok || lat != 13) begin
            bad++; $display("FAIL basic_latency got=%0d ok=%0b want=13", lat, ok);
        end
        total++;
        if (bc != 12) begin
            bad++; $display("FAIL basic_busy_cycles got=%0d want=12", bc);
        end
        total++;
        if (res !== 16'h3969) begin
            bad++; $display("FAIL basic_bcd got=%h want=3969", res);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (io.done !== 1'b0 || io.bcd !== 16'h3969) begin
                bad++;
                $display("FAIL basic_hold cyc=%0d done=%b bcd=%h want done=0 bcd=3969",
                         i, io.done, io.bcd);
            end
        end
    endtask

    task automatic test_values();
        int vals[$];
        int lat, bc;
        logic [15:0] res;
        bit ok;
        vals = '{0, 4095, 9, 5, 99, 1000};
        for (int i = 0; i < 10; i++) vals.push_back(int'($urandom_range(0, 4095)));
        foreach (vals[k]) begin
            convert(vals[k], lat, bc, res, ok);
            total++;
            if (!ok || lat != 13 || res !== ref_bcd(vals[k])) begin
                bad++;
                $display("FAIL value bin=%0d got=%h lat=%0d want=%h lat=13",
                         vals[k], res, lat, ref_bcd(vals[k]));
            end
            tick();
        end
    endtask

    task automatic test_ignore_load();
        int lat, dones;
        logic [15:0] at_done;
        io.bin  = 12'd1234;
        io.load = 1'b1;
        tick();
        io.load = 1'b0;
        lat     = 1;
        dones   = 0;
        at_done = 16'hxxxx;
        for (int i = 0; i < 30; i++) begin
            // Noise load only while still converting, so DONE sees load=0
            io.load = (lat >= 5 && lat <= 11);
            io.bin  = (lat == 5) ? 12'd777 : 12'($urandom);
            if (io.done) begin
                dones++;
                if (dones == 1) begin
                    at_done = io.bcd;
                    total++;
                    if (lat != 13) begin
                        bad++; $display("FAIL ignore_latency got=%0d want=13", lat);
                    end
                end
            end
            tick();
            lat++;
        end
        io.load = 1'b0;
        total++;
        if (dones != 1) begin
            bad++; $display("FAIL ignore_done_count got=%0d want=1", dones);
        end
        total++;
        if (at_done !== 16'h1234) begin
            bad++; $display("FAIL ignore_bcd got=%h want=1234", at_done);
        end
    endtask

    task automatic test_back_to_back();
        int seq[$];
        int n;
        seq = '{2048, 100};
        for (int i = 0; i < 3; i++) seq.push_back(int'($urandom_range(0, 4095)));
        io.bin  = 12'(seq[0]);
        io.load = 1'b1;
        tick();
        for (int k = 0; k < seq.size(); k++) begin
            n = 1;
            while (!io.done && n < 40) begin
                if (k == seq.size() - 1) io.load = 1'b0;
                io.bin = 12'($urandom);
                tick();
                n++;
            end
            total++;
            if (!io.done || n != 13 || io.bcd !== ref_bcd(seq[k])) begin
                bad++;
                $display("FAIL b2b k=%0d gap=%0d bcd=%h want gap=13 bcd=%h",
                         k, n, io.bcd, ref_bcd(seq[k]));
            end
            if (k + 1 < seq.size()) begin
                io.bin  = 12'(seq[k+1]);
                io.load = 1'b1;
            end else begin
                io.load = 1'b0;
            end
            tick();
        end
        io.load = 1'b0;
    endtask

    task automatic test_reset_mid();
        int dones, lat, bc;
        logic [15:0] res;
        bit ok;
        io.bin  = 12'd3000;
        io.load = 1'b1;
        tick();
        io.load = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (io.busy !== 1'b0 || io.bcd !== 16'h0) begin
            bad++; $display("FAIL midreset got busy=%b bcd=%h want busy=0 bcd=0000",
                            io.busy, io.bcd);
        end
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (io.done) dones++;
            tick();
        end
        total++;
        if (dones != 0) begin
            bad++; $display("FAIL midreset_done got=%0d want=0", dones);
        end
        convert(55, lat, bc, res, ok);
        total++;
        if (!ok || res !== 16'h0055) begin
            bad++; $display("FAIL after_reset got=%h ok=%0b want=0055", res, ok);
        end
        tick();
    endtask

    task automatic test_mult_chain();
        int a, b, p, lat, bc;
        logic [15:0] res;
        bit ok;
        a = 45;
        b = 27;
        p = a * b;
        convert(p, lat, bc, res, ok);
        total++;
        if (!ok || res !== 16'h1215) begin
            bad++; $display("FAIL mult_chain got=%h ok=%0b want=1215", res, ok);
        end
        tick();
        rst     = 1'b1;
        io.load = 1'b1;
        io.bin  = 12'd321;
        tick();
        rst     = 1'b0;
        io.load = 1'b0;
        total++;
        if (io.busy !== 1'b0 || io.done !== 1'b0 || io.bcd !== 16'h0) begin
            bad++;
            $display("FAIL rst_beats_load busy=%b done=%b bcd=%h want 0 0 0000",
                     io.busy, io.done, io.bcd);
        end
        tick();
        total++;
        if (io.busy !== 1'b0) begin
            bad++; $display("FAIL rst_beats_load_idle busy=%b want=0", io.busy);
        end
    endtask

    initial begin
        io.load = 1'b0;
        io.bin  = '0;
        #1;
        test_reset();
        test_basic();
        test_values();
        test_ignore_load();
        test_back_to_back();
        test_reset_mid();
        test_mult_chain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
